// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: two master request ports plus the RAM engine side and debug status.
interface ram_port_arbiter_if #(parameter int CNT_W = 8);
  logic a_req, a_we, a_ack, b_req, b_we, b_ack;
  logic [16:0] a_addr, b_addr, mem_addr;
  logic [15:0] a_wdata, a_rdata, b_wdata, b_rdata, mem_wdata, mem_rdata;
  logic mem_re, mem_we, mem_done, busy, grant_b, timeout_err;
  logic [CNT_W-1:0] rd_cnt, wr_cnt, to_cnt;
  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_done, mem_rdata,
    output a_ack, a_rdata, b_ack, b_rdata, mem_re, mem_we, mem_addr, mem_wdata,
    output busy, grant_b, timeout_err, rd_cnt, wr_cnt, to_cnt
  );
  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_done, mem_rdata,
    input  a_ack, a_rdata, b_ack, b_rdata, mem_re, mem_we, mem_addr, mem_wdata,
    input  busy, grant_b, timeout_err, rd_cnt, wr_cnt, to_cnt
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of the SRAM access engine between two masters, with timeout.
module ram_port_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input logic clk,
  input logic rst,
  ram_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic last_b_q, last_b_d, grant_b_q, grant_b_d, we_q, we_d;
  logic mem_re_q, mem_re_d, mem_we_q, mem_we_d, a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic busy_q, busy_d, terr_q, terr_d, pick_b, done_ok, abort;
  logic [16:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d, a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, to_cnt_q, to_cnt_d;
  // B wins only when A is idle or A held the previous grant
  assign pick_b = bus.b_req & (~bus.a_req | ~last_b_q);
  always_comb begin
    state_d   = state_q;
    last_b_d  = last_b_q;
    grant_b_d = grant_b_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tcnt_d    = tcnt_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    to_cnt_d  = to_cnt_q;
    terr_d    = terr_q;
    mem_re_d  = 1'b0;
    mem_we_d  = 1'b0;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    done_ok   = 1'b0;
    abort     = 1'b0;
    case (state_q)
      IDLE: if (bus.a_req | bus.b_req) begin
        state_d   = ISSUE;
        grant_b_d = pick_b;
        last_b_d  = pick_b;
        we_d      = pick_b ? bus.b_we : bus.a_we;
        addr_d    = pick_b ? bus.b_addr : bus.a_addr;
        wdata_d   = pick_b ? bus.b_wdata : bus.a_wdata;
        mem_re_d  = ~we_d;
        mem_we_d  = we_d;
      end
      ISSUE: begin
        tcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        tcnt_d  = tcnt_q + 8'd1;
        done_ok = bus.mem_done;
        abort   = ~bus.mem_done & (tcnt_d == 8'(TIMEOUT));
        state_d = (done_ok | abort) ? RESP : WAIT;
      end
      default: state_d = IDLE;
    endcase
    if (done_ok | abort) begin
      a_ack_d = ~grant_b_q;
      b_ack_d = grant_b_q;
    end
    if (done_ok) begin
      rd_cnt_d = we_q ? rd_cnt_q : rd_cnt_q + CNT_W'(1);
      wr_cnt_d = we_q ? wr_cnt_q + CNT_W'(1) : wr_cnt_q;
    end
    if (abort) begin
      terr_d   = 1'b1;
      to_cnt_d = to_cnt_q + CNT_W'(1);
    end
    // aborted transactions return all-ones regardless of direction
    if ((done_ok & ~we_q) | abort) begin
      a_rdata_d = grant_b_q ? a_rdata_q : (abort ? 16'hFFFF : bus.mem_rdata);
      b_rdata_d = grant_b_q ? (abort ? 16'hFFFF : bus.mem_rdata) : b_rdata_q;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_b_q  <= 1'b1;
      grant_b_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tcnt_q    <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      to_cnt_q  <= '0;
      terr_q    <= 1'b0;
      mem_re_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_b_q  <= last_b_d;
      grant_b_q <= grant_b_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tcnt_q    <= tcnt_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      to_cnt_q  <= to_cnt_d;
      terr_q    <= terr_d;
      mem_re_q  <= mem_re_d;
      mem_we_q  <= mem_we_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      busy_q    <= busy_d;
    end
  end
  assign bus.mem_re      = mem_re_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.a_ack       = a_ack_q;
  assign bus.b_ack       = b_ack_q;
  assign bus.a_rdata     = a_rdata_q;
  assign bus.b_rdata     = b_rdata_q;
  assign bus.busy        = busy_q;
  assign bus.grant_b     = grant_b_q;
  assign bus.timeout_err = terr_q;
  assign bus.rd_cnt      = rd_cnt_q;
  assign bus.wr_cnt      = wr_cnt_q;
  assign bus.to_cnt      = to_cnt_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: cycle-timeline model of the arbiter plus directed transactions and literal checks.
module tb_ram_port_arbiter;
  localparam int TO = 15;
  logic clk, rst;
  ram_port_arbiter_if #(.CNT_W(8)) bus ();
  ram_port_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // model: transaction timeline expressed as cycle numbers (strobe at s, WAIT window s+1..s+TO)
  int cyc = 0, s = 0, free_at = 0;
  bit act = 0, chk_en = 0;
  logic e_re, e_we, e_aack, e_back, e_busy, e_gb, e_terr, m_lastb, m_we;
  logic [16:0] e_addr;
  logic [15:0] e_wdata, e_ard, e_brd;
  logic [7:0] e_rd, e_wr, e_to;
  always @(posedge clk) begin
    cyc++;
    e_re = 0; e_we = 0; e_aack = 0; e_back = 0;
    if (rst) begin
      chk_en = 1; act = 0; free_at = cyc; e_busy = 0;
      e_addr = 0; e_wdata = 0; e_ard = 0; e_brd = 0; e_gb = 0; e_terr = 0;
      m_lastb = 1; m_we = 0; e_rd = 0; e_wr = 0; e_to = 0;
    end else begin
      if (act && cyc - 1 > s && cyc - 1 <= s + TO && (bus.mem_done === 1'b1 || cyc - 1 == s + TO)) begin
        act = 0; free_at = cyc + 1;
        if (e_gb) e_back = 1; else e_aack = 1;
        if (bus.mem_done !== 1'b1) begin
          e_terr = 1; e_to++;
          if (e_gb) e_brd = 16'hFFFF; else e_ard = 16'hFFFF;
        end else if (m_we) e_wr++;
        else begin
          e_rd++;
          if (e_gb) e_brd = bus.mem_rdata; else e_ard = bus.mem_rdata;
        end
      end else if (!act && cyc - 1 >= free_at && (bus.a_req || bus.b_req)) begin
        e_gb = bus.b_req && (!bus.a_req || !m_lastb);
        m_lastb = e_gb; act = 1; s = cyc;
        m_we = e_gb ? bus.b_we : bus.a_we;
        e_addr = e_gb ? bus.b_addr : bus.a_addr;
        e_wdata = e_gb ? bus.b_wdata : bus.a_wdata;
        e_re = !m_we; e_we = m_we;
      end
      e_busy = act || e_aack || e_back;
    end
  end
  // engine responder: mem_done pulses done_k cycles after the strobe (0 = never)
  int rcnt = 0, done_k = 0;
  bit spur = 0;
  always @(negedge clk) begin
    if (rcnt > 0) begin
      rcnt--;
      bus.mem_done = (rcnt == 0) || spur;
    end else bus.mem_done = spur;
    if ((bus.mem_re === 1'b1 || bus.mem_we === 1'b1) && done_k > 0) rcnt = done_k;
  end
  int tests = 0, fails = 0, strobe_cyc = 0, n_aack = 0, n_back = 0;
  logic [16:0] s_addr;
  logic [15:0] s_wdata;
  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    tests++;
    if (act_v !== exp_v) begin
      fails++;
      if (fails < 40) $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act_v, exp_v);
    end
  endtask
  task automatic compare();
    if (!chk_en) return;
    chk("mem_re", 32'(bus.mem_re), 32'(e_re));
    chk("mem_we", 32'(bus.mem_we), 32'(e_we));
    chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
    chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
    chk("a_ack", 32'(bus.a_ack), 32'(e_aack));
    chk("b_ack", 32'(bus.b_ack), 32'(e_back));
    chk("a_rdata", 32'(bus.a_rdata), 32'(e_ard));
    chk("b_rdata", 32'(bus.b_rdata), 32'(e_brd));
    chk("busy", 32'(bus.busy), 32'(e_busy));
    chk("grant_b", 32'(bus.grant_b), 32'(e_gb));
    chk("timeout_err", 32'(bus.timeout_err), 32'(e_terr));
    chk("rd_cnt", 32'(bus.rd_cnt), 32'(e_rd));
    chk("wr_cnt", 32'(bus.wr_cnt), 32'(e_wr));
    chk("to_cnt", 32'(bus.to_cnt), 32'(e_to));
  endtask
  task automatic tick();
    @(negedge clk);
    compare();
    if (bus.mem_re === 1'b1 || bus.mem_we === 1'b1) begin
      strobe_cyc = cyc; s_addr = bus.mem_addr; s_wdata = bus.mem_wdata;
    end
    if (bus.a_ack === 1'b1) n_aack++;
    if (bus.b_ack === 1'b1) n_back++;
  endtask
  task automatic txn(input bit pb, input logic we, input logic [16:0] addr, input logic [15:0] wd,
                     input int k, input bit mutate, output int ack_cyc, output logic [15:0] rd);
    done_k = k;
    ack_cyc = -1;
    rd = 16'h0;
    if (pb) begin bus.b_req = 1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd; end
    else begin bus.a_req = 1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd; end
    for (int i = 0; i < 60; i++) begin
      tick();
      if (mutate && !pb && cyc == strobe_cyc) begin bus.a_addr = 17'h0FFFF; bus.a_wdata = 16'h0; end
      if ((pb ? bus.b_ack : bus.a_ack) === 1'b1) begin
        ack_cyc = cyc; rd = pb ? bus.b_rdata : bus.a_rdata;
        break;
      end
    end
    if (pb) bus.b_req = 0; else bus.a_req = 0;
    chk("txn_ack_seen", 32'(ack_cyc >= 0), 32'd1);
  endtask
  int n0, ac, acks, na;
  logic [15:0] rd;
  logic [3:0] order;
  initial begin
    rst = 1; spur = 0;
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0;
    bus.mem_rdata = 0; bus.mem_done = 0;
    repeat (2) tick();
    rst = 0;
    tick();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_grant_b", 32'(bus.grant_b), 0);
    chk("rst_rd_cnt", 32'(bus.rd_cnt), 0);
    chk("rst_a_rdata", 32'(bus.a_rdata), 0);
    // A write, done two cycles after strobe
    n0 = cyc;
    txn(0, 1, 17'h00005, 16'h1234, 2, 0, ac, rd);
    chk("wr_lat", 32'(ac - n0), 32'd4);
    chk("wr_strobe_at", 32'(strobe_cyc - n0), 32'd1);
    chk("wr_addr", 32'(s_addr), 32'h00005);
    chk("wr_data", 32'(s_wdata), 32'h1234);
    chk("wr_cnt1", 32'(bus.wr_cnt), 32'd1);
    repeat (2) tick();
    // B read from RAM2, minimum latency
    bus.mem_rdata = 16'hBEEF;
    n0 = cyc;
    txn(1, 0, 17'h10003, 16'h0, 1, 0, ac, rd);
    chk("rd_data", 32'(rd), 32'hBEEF);
    chk("rd_lat", 32'(ac - n0), 32'd3);
    chk("rd_addr", 32'(s_addr), 32'h10003);
    chk("rd_cnt1", 32'(bus.rd_cnt), 32'd1);
    chk("rd_no_a_ack", 32'(n_aack), 32'd1);
    chk("rd_grant_b", 32'(bus.grant_b), 32'd1);
    repeat (2) tick();
    // contention: strict alternation starting with A
    done_k = 1; bus.mem_rdata = 16'h5A5A; acks = 0; order = 0;
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 17'h00011;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 17'h10022;
    for (int i = 0; i < 80 && acks < 4; i++) begin
      tick();
      if (bus.a_ack === 1'b1) begin order = {order[2:0], 1'b0}; acks++; end
      if (bus.b_ack === 1'b1) begin order = {order[2:0], 1'b1}; acks++; end
    end
    bus.a_req = 0; bus.b_req = 0;
    chk("cont_acks", 32'(acks), 32'd4);
    chk("cont_order", 32'(order), 32'b0101);
    chk("cont_rd_cnt", 32'(bus.rd_cnt), 32'd5);
    repeat (2) tick();
    // timeout: engine never answers
    bus.mem_rdata = 16'h1111;
    txn(0, 0, 17'h00042, 16'h0, 0, 0, ac, rd);
    chk("to_ack_after_strobe", 32'(ac - strobe_cyc), 32'(TO + 1));
    chk("to_rdata", 32'(rd), 32'hFFFF);
    chk("to_err", 32'(bus.timeout_err), 32'd1);
    chk("to_cnt1", 32'(bus.to_cnt), 32'd1);
    chk("to_rd_cnt", 32'(bus.rd_cnt), 32'd5);
    repeat (2) tick();
    // request fields changed after grant are ignored
    bus.mem_rdata = 16'hC0DE;
    txn(0, 0, 17'h00777, 16'h0, 4, 1, ac, rd);
    chk("mut_addr", 32'(bus.mem_addr), 32'h00777);
    chk("mut_rdata", 32'(rd), 32'hC0DE);
    chk("mut_rd_cnt", 32'(bus.rd_cnt), 32'd6);
    repeat (2) tick();
    // mem_done while idle does nothing
    na = n_aack + n_back; spur = 1;
    repeat (3) tick();
    spur = 0;
    repeat (2) tick();
    chk("spur_busy", 32'(bus.busy), 0);
    chk("spur_no_ack", 32'(n_aack + n_back), 32'(na));
    // reset during WAIT
    done_k = 0;
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 17'h00100;
    repeat (3) tick();
    chk("mid_busy_before", 32'(bus.busy), 32'd1);
    rst = 1; bus.a_req = 0;
    tick();
    rst = 0;
    chk("mid_busy", 32'(bus.busy), 0);
    chk("mid_re", 32'(bus.mem_re), 0);
    chk("mid_rd_cnt", 32'(bus.rd_cnt), 0);
    chk("mid_to_cnt", 32'(bus.to_cnt), 0);
    chk("mid_terr", 32'(bus.timeout_err), 0);
    na = n_aack + n_back;
    repeat (20) tick();
    chk("mid_no_ack", 32'(n_aack + n_back), 32'(na));
    // fresh tie after reset goes to A first
    done_k = 1; acks = 0; order = 0;
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 17'h00200; bus.a_wdata = 16'hAAAA;
    bus.b_req = 1; bus.b_we = 1; bus.b_addr = 17'h10200; bus.b_wdata = 16'hBBBB;
    for (int i = 0; i < 40 && acks < 2; i++) begin
      tick();
      if (bus.a_ack === 1'b1) begin order = {order[2:0], 1'b0}; acks++; end
      if (bus.b_ack === 1'b1) begin order = {order[2:0], 1'b1}; acks++; end
    end
    bus.a_req = 0; bus.b_req = 0;
    chk("post_acks", 32'(acks), 32'd2);
    chk("post_order", 32'(order[1:0]), 32'b01);
    chk("post_wr_cnt", 32'(bus.wr_cnt), 32'd2);
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
